// File: rtl/seq_mult_mxn.sv
// seq_mult_mxn: iterative shift-add multiplier, WA x WB, unsigned or signed.
// Operands are converted to magnitudes when accepted. The product is built
// one multiplier bit per cycle. The sign is applied when p is loaded.
module seq_mult_mxn #(
  parameter int WA = 4,
  parameter int WB = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WA-1:0]    a,
  input  logic [WB-1:0]    b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WA+WB-1:0] p
);

  localparam int CW = (WB > 1) ? $clog2(WB) : 1;
  localparam int PW = WA + 1 + WB;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [WA-1:0]   mcand;
  logic [WB-1:0]   mplier;
  logic [WA:0]     acc;
  logic [CW-1:0]   cnt;
  logic            neg;

  logic [WA-1:0]   mag_a;
  logic [WB-1:0]   mag_b;
  logic [WA:0]     sum;
  logic [PW-1:0]   pair_nxt;
  logic [WA+WB-1:0] mag_prod;
  logic            last;

  // Operand magnitudes. The most-negative value maps to its unsigned
  // magnitude (e.g. 4'b1000 -> 8), so no extra bit is needed.
  always_comb begin
    mag_a = (is_signed && a[WA-1]) ? -a : a;
    mag_b = (is_signed && b[WB-1]) ? -b : b;
  end

  // One shift-add step. The accumulator stays below 2^WA after each shift,
  // so the conditional add fits in WA+1 bits.
  always_comb begin
    sum      = mplier[0] ? (acc + {1'b0, mcand}) : acc;
    pair_nxt = {sum, mplier} >> 1;
    mag_prod = pair_nxt[WA+WB-1:0];
    last     = (cnt == CW'(WB - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are pure state decodes.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath: capture operands, iterate, and load the signed result.
  // The signed-mode flag only matters through neg and the magnitudes, so it
  // is folded into neg when the operands are accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      p      <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mcand  <= mag_a;
          mplier <= mag_b;
          neg    <= is_signed & (a[WA-1] ^ b[WB-1]);
          acc    <= '0;
          cnt    <= '0;
        end
        RUN: begin
          acc    <= pair_nxt[PW-1:WB];
          mplier <= pair_nxt[WB-1:0];
          cnt    <= cnt + CW'(1);
          // Negating a zero magnitude gives zero, so no sign fix-up is needed.
          if (last) p <= neg ? -mag_prod : mag_prod;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_mult_mxn.md
# seq_mult_mxn

Iterative shift-add multiplier for WA-bit by WB-bit operands, in unsigned or two's-complement signed mode. It is the parametrised, registered-handshake successor to the 4xN array multiplier. It trades the array's combinational adder chain for WB clock cycles per product. It sits between a valid/ready operand source and a valid/ready result sink.

## Interface
- WA, default 4, multiplicand (a) width, must be >= 2
- WB, default 8, multiplier (b) width and iteration count, must be >= 2
- clk  input  1  clock, rising edge active
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  operand source has a, b and is_signed valid
- in_ready  output  1  block accepts operands; high only in IDLE
- a  input  WA  multiplicand
- b  input  WB  multiplier
- is_signed  input  1  1 = both operands two's complement; 0 = both unsigned
- out_valid  output  1  p holds a completed product
- out_ready  input  1  result sink accepts p
- p  output  WA+WB  product, registered; two's complement when the op was signed

## Operation
- States are IDLE, RUN and DONE. An iteration counter counts 0..WB-1.
- IDLE: in_ready=1. When in_valid&&in_ready at an edge:
  - is_signed is latched as mode.
  - The magnitudes |a| and |b| are latched; in signed mode the MSB is the sign.
  - neg = mode & (a[WA-1]^b[WB-1]) is latched.
  - The accumulator is cleared, the counter is set to 0 and the state moves to RUN.
- In signed mode, the most-negative value's magnitude (for example 2^(WA-1)) is held as an unsigned WA-bit value. No overflow occurs.
- RUN, one step per cycle:
  - If the multiplier LSB is 1, add the multiplicand into the upper WA+1 bits of the accumulator.
  - Shift the {accumulator, multiplier} pair right by 1 and increment the counter.
  - After the step with counter = WB-1, move to DONE.
  - On that same edge, load p with the magnitude product, two's-complement negated if neg.
- DONE: out_valid=1. p is held stable until out_valid&&out_ready. On that edge: out_valid goes to 0 and the state moves to IDLE.
- in_valid, a, b and is_signed are ignored outside IDLE. Operands may change freely during RUN and DONE.
- Width rules:
  - The unsigned product always fits WA+WB bits.
  - The signed product always fits WA+WB bits, including (-2^(WA-1))*(-2^(WB-1)) = 2^(WA+WB-2).
  - A zero product is never negative: negating 0 gives 0.
- Reset (rst=0) at any time, including mid-RUN or in DONE, takes effect immediately:
  - state=IDLE, out_valid=0, p=0, accumulator and counter cleared, in_ready=1.
  - An in-flight operation is discarded and never produces out_valid.

## Timing
- Reset values: in_ready=1, out_valid=0, p=0.
- Accept edge T0 is the edge where in_valid&&in_ready.
  - in_ready falls immediately after T0.
  - RUN spans edges T0+1 .. T0+WB.
  - p and out_valid are updated at edge T0+WB, so out_valid is high during cycle T0+WB..
- Latency is WB cycles from accept edge to out_valid high.
- If out_ready is already 1, the result handshake occurs at edge T0+WB+1 and the state is IDLE after it.
- The next accept can occur at edge T0+WB+2 at the earliest. Peak throughput is one product per WB+2 cycles.
- in_ready is a decode of state==IDLE, with no combinational path from in_valid.
- out_valid is a decode of state==DONE, with no combinational path from out_ready.
- Backpressure: while out_ready=0 in DONE, p and out_valid hold indefinitely and in_ready stays 0.

## Test plan
- Reset check, WA=4, WB=8: hold rst=0 for 3 cycles, then release -> in_ready=1, out_valid=0, p=0.
- Unsigned exhaustive, WA=4, WB=8, out_ready=1:
  - Drive every a in 0..15 and b in 0..255.
  - Required: p equals a*b exactly (for example 15*255 -> 3825).
  - Required: out_valid rises exactly 8 cycles after each accept edge.
- Signed corners, WA=4, WB=8:
  - -8*-128 -> p=1024.
  - -8*127 -> p=-1016 (12'hC08).
  - 7*-1 -> p=-7.
  - 0*-128 -> p=0.
  - -1*-1 -> p=1.
- Backpressure:
  - Hold out_ready=0 for 20 cycles after out_valid rises -> p stable, in_ready=0 throughout.
  - While in RUN and DONE, change a and b and pulse in_valid -> no effect on p.
- Reset mid-operation:
  - Assert rst for 1 cycle during RUN step 4 of 3*5 -> out_valid stays 0 and in_ready=1 after release.
  - Then a new 2*2 -> p=4 with normal latency.
- Parameter sweep (WA,WB) = (4,4), (8,3), (16,16):
  - Run random signed and unsigned operands against a reference model.
  - Required: all products match, and latency equals WB cycles in each configuration.
